// File: rtl/pwm_serializer.sv
// pwm_serializer: fixed-frequency PWM transmitter. A duty value in whole percent
// is accepted through a valid/ready handshake into a one-entry pending buffer.
// The buffered value is applied only at a window boundary, so every period
// on the line is complete and glitch-free.
module pwm_serializer #(
    parameter int WAVE_FREQ = 10,
    parameter int SYS_FREQ  = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] duty_cycle,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       signal,
    output logic       period_start,
    output logic [6:0] active_duty
);

    // Cycles per PWM period and cycles per percent of duty.
    localparam int WAVE_WINDOW = SYS_FREQ / WAVE_FREQ;
    localparam int STEP        = WAVE_WINDOW / 100;
    localparam int CW          = $clog2(WAVE_WINDOW) + 1;

    localparam logic [CW-1:0] LAST_COUNT = CW'(WAVE_WINDOW - 1);
    localparam logic [CW-1:0] ZERO_COUNT = CW'(0);
    localparam logic [CW-1:0] ONE_COUNT  = CW'(1);

    // Run-state encoding: IDLE holds the line low, RUN sweeps the window.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Saturate a requested duty to 100 percent.
    function automatic logic [6:0] clamp_duty(input logic [6:0] d);
        logic [6:0] r;
        if (d > 7'd100) begin
            r = 7'd100;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Number of high cycles in a window for a given duty; 32 bits covers 100*STEP.
    function automatic logic [31:0] high_len(input logic [6:0] d);
        return 32'(d) * 32'(STEP);
    endfunction

    // Registered state
    logic [0:0]    state_r;
    logic [CW-1:0] count_r;
    logic [6:0]    active_duty_r;
    logic [6:0]    pend_val_r;
    logic          pend_full_r;
    logic          ready_r;
    logic          signal_r;
    logic          period_start_r;

    // Next-state values
    logic [0:0]    state_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [6:0]    active_duty_nxt_s;
    logic [6:0]    pend_val_nxt_s;
    logic          pend_full_nxt_s;
    logic          signal_nxt_s;
    logic          period_start_nxt_s;
    logic          handshake_s;
    logic          boundary_s;

    // Window sequencing, buffer handling and next output values.
    always_comb begin
        handshake_s        = duty_valid && ready_r;
        boundary_s         = 1'b0;
        state_nxt_s        = state_r;
        count_nxt_s        = ZERO_COUNT;
        active_duty_nxt_s  = active_duty_r;
        pend_val_nxt_s     = pend_val_r;
        pend_full_nxt_s    = pend_full_r;
        signal_nxt_s       = 1'b0;
        period_start_nxt_s = 1'b0;

        // A boundary is entry into count 0: first enabled cycle or wrap.
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_RUN;
                    boundary_s  = 1'b1;
                    count_nxt_s = ZERO_COUNT;
                end else begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_COUNT;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Window abandoned; the line goes low next cycle.
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = ZERO_COUNT;
                end else if (count_r >= LAST_COUNT) begin
                    // Out-of-range counts are folded into a wrap as well.
                    state_nxt_s = ST_RUN;
                    boundary_s  = 1'b1;
                    count_nxt_s = ZERO_COUNT;
                end else begin
                    state_nxt_s = ST_RUN;
                    count_nxt_s = count_r + ONE_COUNT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = ZERO_COUNT;
            end
        endcase

        // The buffer content before this edge is what a boundary applies.
        if (boundary_s && pend_full_r) begin
            active_duty_nxt_s = pend_val_r;
        end else begin
            active_duty_nxt_s = active_duty_r;
        end

        // Handshake only happens with an empty buffer, so it never collides
        // with a consume; a same-edge accept waits for the next boundary.
        if (handshake_s) begin
            pend_val_nxt_s  = clamp_duty(duty_cycle);
            pend_full_nxt_s = 1'b1;
        end else if (boundary_s && pend_full_r) begin
            pend_val_nxt_s  = pend_val_r;
            pend_full_nxt_s = 1'b0;
        end else begin
            pend_val_nxt_s  = pend_val_r;
            pend_full_nxt_s = pend_full_r;
        end

        // Line is high for the first H cycles of the window, H from the duty
        // in force for the cycle being produced.
        if (state_nxt_s == ST_RUN) begin
            signal_nxt_s       = (32'(count_nxt_s) < high_len(active_duty_nxt_s));
            period_start_nxt_s = boundary_s;
        end else begin
            signal_nxt_s       = 1'b0;
            period_start_nxt_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            count_r        <= ZERO_COUNT;
            active_duty_r  <= 7'd0;
            pend_val_r     <= 7'd0;
            pend_full_r    <= 1'b0;
            ready_r        <= 1'b0;
            signal_r       <= 1'b0;
            period_start_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            count_r        <= count_nxt_s;
            active_duty_r  <= active_duty_nxt_s;
            pend_val_r     <= pend_val_nxt_s;
            pend_full_r    <= pend_full_nxt_s;
            ready_r        <= !pend_full_nxt_s;
            signal_r       <= signal_nxt_s;
            period_start_r <= period_start_nxt_s;
        end
    end

    assign duty_ready   = ready_r;
    assign signal       = signal_r;
    assign period_start = period_start_r;
    assign active_duty  = active_duty_r;

endmodule

// File: tb/tb_pwm_serializer.sv
// Scoreboard bench for pwm_serializer (WAVE_WINDOW=1000, STEP=10).
// Stimulus pushes the expected duty/high-count of every complete window; a
// monitor measures each window on the line and compares against the queue.
module tb_pwm_serializer;

    localparam int W = 1000;

    typedef struct {
        int duty;
        int high;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [6:0] duty_cycle;
    logic       duty_valid;
    logic       duty_ready;
    logic       signal;
    logic       period_start;
    logic [6:0] active_duty;

    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    logic abort;

    // Monitor-owned window measurement state
    logic win_open;
    logic expect_start;
    logic seen_low;
    logic glitch;
    int   win_len;
    int   win_high;
    int   win_duty;
    exp_t e;

    pwm_serializer #(
        .WAVE_FREQ(10),
        .SYS_FREQ (10000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .duty_cycle  (duty_cycle),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .signal      (signal),
        .period_start(period_start),
        .active_duty (active_duty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance until the next period_start; bounded so a dead line cannot hang.
    task automatic wait_pstart(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (period_start !== 1'b1 && n < 1100);
        if (period_start !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_pstart: no period_start within %0d cycles", n);
        end
    endtask

    // One-cycle handshake; buffer must be empty beforehand and full afterwards.
    task automatic send(input logic [6:0] d);
        check("ready_before_send", {31'd0, duty_ready}, 32'd1);
        duty_cycle = d;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
        check("ready_after_send", {31'd0, duty_ready}, 32'd0);
    endtask

    task automatic push(input int duty, input int high);
        exp_t x;
        x.duty = duty;
        x.high = high;
        sb.push_back(x);
    endtask

    // Window monitor: measures each window and compares with the scoreboard.
    initial begin
        win_open     = 1'b0;
        expect_start = 1'b0;
        seen_low     = 1'b0;
        glitch       = 1'b0;
        win_len      = 0;
        win_high     = 0;
        win_duty     = 0;
        forever begin
            @(negedge clk);
            if (abort) begin
                win_open     = 1'b0;
                expect_start = 1'b0;
            end else begin
                if (expect_start && period_start !== 1'b1) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL period_gap: period_start=%0b after full window, expected 1", period_start);
                end
                expect_start = 1'b0;
                if (period_start === 1'b1) begin
                    if (win_open) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL short_window: length %0d expected %0d", win_len, W);
                    end
                    win_open = 1'b1;
                    win_len  = 0;
                    win_high = 0;
                    seen_low = 1'b0;
                    glitch   = 1'b0;
                    win_duty = int'(active_duty);
                end
                if (win_open) begin
                    win_len++;
                    if (signal === 1'b1) begin
                        win_high++;
                        if (seen_low) glitch = 1'b1;
                    end else begin
                        seen_low = 1'b1;
                    end
                    if (win_len == W) begin
                        win_open     = 1'b0;
                        expect_start = 1'b1;
                        n_cmp++;
                        if (sb.size() == 0) begin
                            n_err++;
                            $display("FAIL window: unexpected window duty=%0d high=%0d", win_duty, win_high);
                        end else begin
                            e = sb.pop_front();
                            if (win_duty != e.duty || win_high != e.high || glitch) begin
                                n_err++;
                                $display("FAIL window: got duty=%0d high=%0d split=%0b expected duty=%0d high=%0d split=0",
                                         win_duty, win_high, glitch, e.duty, e.high);
                            end
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int n;
        n_cmp      = 0;
        n_err      = 0;
        abort      = 1'b1;
        reset      = 1'b0;
        enable     = 1'b0;
        duty_cycle = 7'd0;
        duty_valid = 1'b0;

        // Reset values
        ticks(3);
        check("rst_signal", {31'd0, signal}, 32'd0);
        check("rst_pstart", {31'd0, period_start}, 32'd0);
        check("rst_active", {25'd0, active_duty}, 32'd0);
        check("rst_ready_held", {31'd0, duty_ready}, 32'd0);
        reset = 1'b1;
        tick();
        check("rst_ready_release", {31'd0, duty_ready}, 32'd1);

        // Enabled with no duty loaded: three all-low windows, 1000-cycle spacing
        abort  = 1'b0;
        push(0, 0);
        push(0, 0);
        push(0, 0);
        enable = 1'b1;
        tick();
        check("s1_first_pstart", {31'd0, period_start}, 32'd1);
        check("s1_active", {25'd0, active_duty}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            wait_pstart(n);
            check("s1_spacing", n, W);
        end
        abort  = 1'b1;
        enable = 1'b0;
        tick();

        // Load 37 while disabled, then enable
        send(7'd37);
        push(37, 370);
        abort  = 1'b0;
        enable = 1'b1;
        tick();
        check("s2_pstart", {31'd0, period_start}, 32'd1);
        check("s2_signal", {31'd0, signal}, 32'd1);
        check("s2_active", {25'd0, active_duty}, 32'd37);
        check("s2_ready", {31'd0, duty_ready}, 32'd1);

        // Mid-window load of 80 at count 500; a second offer is refused
        ticks(500);
        send(7'd80);
        push(80, 800);
        push(80, 800);
        duty_cycle = 7'd55;
        duty_valid = 1'b1;
        ticks(50);
        check("s3_busy_ready", {31'd0, duty_ready}, 32'd0);
        duty_valid = 1'b0;
        wait_pstart(n);
        check("s3_active", {25'd0, active_duty}, 32'd80);
        check("s3_ready_back", {31'd0, duty_ready}, 32'd1);
        wait_pstart(n);

        // 120 clamps to 100: solid high across the wrap, then 0: solid low
        send(7'd120);
        push(100, 1000);
        push(100, 1000);
        wait_pstart(n);
        check("s4_clamped", {25'd0, active_duty}, 32'd100);
        check("s4_high_start", {31'd0, signal}, 32'd1);
        wait_pstart(n);
        check("s4_high_wrap", {31'd0, signal}, 32'd1);
        send(7'd0);
        push(0, 0);
        wait_pstart(n);
        check("s4_zero_active", {25'd0, active_duty}, 32'd0);
        check("s4_zero_signal", {31'd0, signal}, 32'd0);

        // Handshake exactly on the wrap edge with 50 active, 20 offered
        send(7'd50);
        push(50, 500);
        wait_pstart(n);
        check("s5_active50", {25'd0, active_duty}, 32'd50);
        ticks(999);
        check("s5_last_pstart", {31'd0, period_start}, 32'd0);
        check("s5_last_signal", {31'd0, signal}, 32'd0);
        push(50, 500);
        push(20, 200);
        send(7'd20);
        check("s5_wrap_pstart", {31'd0, period_start}, 32'd1);
        check("s5_wrap_active", {25'd0, active_duty}, 32'd50);
        wait_pstart(n);
        check("s5_active20", {25'd0, active_duty}, 32'd20);
        wait_pstart(n);

        // Drop enable at count 200
        ticks(200);
        abort  = 1'b1;
        enable = 1'b0;
        tick();
        check("s6_dis_signal", {31'd0, signal}, 32'd0);
        check("s6_dis_pstart", {31'd0, period_start}, 32'd0);
        check("s6_dis_count", 32'(dut.count_r), 32'd0);
        check("s6_dis_active", {25'd0, active_duty}, 32'd20);
        send(7'd90);
        ticks(5);
        check("s6_dis_hold", {25'd0, active_duty}, 32'd20);
        enable = 1'b1;
        tick();
        check("s6_reen_pstart", {31'd0, period_start}, 32'd1);
        check("s6_reen_active", {25'd0, active_duty}, 32'd90);

        // Reset pulse at count 600 with a value pending
        ticks(300);
        send(7'd60);
        ticks(299);
        reset = 1'b0;
        tick();
        check("s6_rst_signal", {31'd0, signal}, 32'd0);
        check("s6_rst_pstart", {31'd0, period_start}, 32'd0);
        check("s6_rst_active", {25'd0, active_duty}, 32'd0);
        check("s6_rst_ready", {31'd0, duty_ready}, 32'd0);
        reset = 1'b1;
        abort = 1'b0;
        push(0, 0);
        tick();
        check("s6_post_ready", {31'd0, duty_ready}, 32'd1);
        check("s6_post_pstart", {31'd0, period_start}, 32'd1);
        check("s6_post_active", {25'd0, active_duty}, 32'd0);
        wait_pstart(n);
        check("s6_pending_lost", {25'd0, active_duty}, 32'd0);
        ticks(2);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_serializer.md
# pwm_serializer

Generates a fixed-frequency PWM waveform whose duty cycle, in whole percent, is supplied through a valid/ready handshake. It is the transmit end of the PWM link: its `signal` output drives the line that the PWM deserializer measures. New duty values are buffered and take effect only at a window boundary, so no period is ever truncated or glitched.

## Interface
- `WAVE_FREQ`, default 10: PWM period frequency in Hz.
- `SYS_FREQ`, default 100000: `clk` frequency in Hz.
- Derived constants:
  - WAVE_WINDOW = SYS_FREQ/WAVE_FREQ (cycles per period).
  - STEP = WAVE_WINDOW/100 (cycles per percent).
  - Both must be integers; WAVE_WINDOW must be ≥ 100.

- `clk` input 1: system clock, all logic on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `enable` input 1: 1 = generate the waveform; 0 = idle with the line low.
- `duty_cycle` input 7: requested duty in percent; values above 100 are clamped to 100.
- `duty_valid` input 1: `duty_cycle` is presented.
- `duty_ready` output 1: the pending buffer is empty and can accept a value.
- `signal` output 1: registered PWM output.
- `period_start` output 1: one-cycle pulse on the first cycle of each window.
- `active_duty` output 7: duty (0-100) currently being generated.

## Operation
- **Storage**
  - `count`: window counter, width $clog2(WAVE_WINDOW)+1.
  - `active_duty` register.
  - One-entry pending buffer: `pend_val` (7 bits) plus `pend_full`.
- **Accept**
  - A handshake occurs when `duty_valid && duty_ready`.
  - On a handshake, `pend_val` <= min(`duty_cycle`, 100) and `pend_full` <= 1.
  - `duty_ready` = !`pend_full`; it is registered-state derived and does not depend combinationally on `duty_valid`.
- **Counting**
  - While `enable` = 1, `count` steps 0 → WAVE_WINDOW-1, then wraps to 0.
  - While `enable` = 0, `count` is held at 0.
- **Boundary**
  - A boundary is the cycle in which the counter transitions into 0: the wrap from WAVE_WINDOW-1, or the first enabled cycle after `enable` rises.
  - On a boundary, if `pend_full` is set: `active_duty` <= `pend_val` and `pend_full` <= 0.
  - The applied value is the one held in the buffer before that edge.
  - A handshake on the same edge as a boundary is stored in the buffer and applies at the following boundary.
- **Output**
  - In each window, `signal` is high for exactly H = `active_duty`*STEP consecutive cycles, starting in the cycle where `period_start` = 1, and low for the remaining WAVE_WINDOW-H cycles.
  - Duty 0 gives a constant low line; duty 100 gives a constant high line with no dip at the wrap.
  - H uses the `active_duty` in force for that window; the multiplication is unsigned and wide enough for 100*STEP.
- **Disable**
  - When `enable` is 0, `signal` = 0 and `period_start` = 0.
  - The pending buffer still accepts a value and `active_duty` holds.
  - If `enable` falls mid-window, that window is abandoned; `signal` is 0 from the next cycle.

## Timing
- **Reset (`reset` = 0 at an edge)**
  - `count` = 0, `active_duty` = 0, `pend_full` = 0, `signal` = 0, `period_start` = 0.
  - `duty_ready` = 0 while `reset` is held low, and 1 from the first cycle after release.
  - Reset mid-window discards the pending value.
- **Enable rise**
  - `enable` sampled 1 at edge N: `period_start` and the first high cycle of `signal` (if H > 0) appear in cycle N+1.
  - A pending value accepted at or before edge N-1 applies to that first window.
- **Duty change latency**: from the accept edge to the new duty on `signal`, ≤ WAVE_WINDOW+1 cycles.
- **Buffer full**: `duty_ready` drops the cycle after an accept and rises the cycle after the boundary that consumes the value.
- **Period**: `period_start` pulses exactly every WAVE_WINDOW cycles while `enable` stays high.

## Test plan
All scenarios use WAVE_FREQ=10, SYS_FREQ=10000 (WAVE_WINDOW=1000, STEP=10).
- Reset, then `enable`=1 with no duty loaded:
  - `signal` is low for 3000 cycles.
  - `period_start` pulses at 1000-cycle spacing.
  - `active_duty` = 0.
- Load duty 37 while disabled, then enable:
  - The first window has `signal` high for exactly 370 cycles, starting with `period_start`.
  - `active_duty` = 37; `duty_ready` returns to 1.
- Mid-window at count 500 with duty 37 active, load 80:
  - The current window finishes with 370 high cycles.
  - The next window has 800 high cycles.
  - A second `duty_valid` sent before that boundary is not accepted (`duty_ready` = 0).
- Present `duty_cycle` = 120:
  - `active_duty` = 100; `signal` stays high across the wrap for 2 full windows.
  - Then load 0: `signal` stays low for the whole next window.
- Assert a handshake exactly on the wrap edge, with duty 50 active and 20 presented:
  - The next window uses 50.
  - The window after that uses 20.
- Drop `enable` at count 200, and separately pulse `reset` low at count 600:
  - After the `enable` drop, `signal` = 0 on the next cycle and `count` = 0.
  - After the `reset` pulse, all outputs take their reset values, `active_duty` = 0, and the pending value is lost.
